// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer hold-off logic.
// The LFSR step function lives here so the generator and any checker agree.
package reaction_pkg;

    localparam int LFSR_W = 7;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b1100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fibonacci step, shift left, parity of tapped bits into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] v
    );
        if (v == '0)
            return LFSR_SEED;
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running x^7+x^6+1 LFSR, advanced only while en is high.
// An all-zero state recovers to the seed on the next step.
module lfsr_gen
    import reaction_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= LFSR_SEED;
        else if (en)
            q <= lfsr_next(q);
    end

endmodule

// File: rtl/random_delay.sv
// Random hold-off timer: captures the LFSR on start_delay and
// pulses time_out once after lfsr*DELAY_UNIT_MS milliseconds.
module random_delay
    import reaction_pkg::*;
#(
    parameter int MS_DIV        = 50000,
    parameter int DELAY_UNIT_MS = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_lfsr,
    input  logic              start_delay,
    output logic              time_out,
    output logic              busy,
    output logic [LFSR_W-1:0] delay_val
);

    localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int UW = (DELAY_UNIT_MS > 1) ? $clog2(DELAY_UNIT_MS) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(MS_DIV - 1);
    localparam logic [UW-1:0] UNIT_MAX = UW'(DELAY_UNIT_MS - 1);
    localparam logic [LFSR_W-1:0] ONE  = LFSR_W'(1);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] remaining;
    logic [PW-1:0]     prescaler;
    logic [UW-1:0]     unit_ms;
    state_t            state;

    lfsr_gen u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_lfsr),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            delay_val <= '0;
            remaining <= '0;
            prescaler <= '0;
            unit_ms   <= '0;
            time_out  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    time_out <= 1'b0;
                    if (start_delay) begin
                        delay_val <= lfsr_q;
                        remaining <= lfsr_q;
                        prescaler <= '0;
                        unit_ms   <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // A dropped request wins over a same-cycle expiry.
                    if (!start_delay) begin
                        prescaler <= '0;
                        unit_ms   <= '0;
                        remaining <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (prescaler == PRE_MAX) begin
                        prescaler <= '0;
                        if (unit_ms == UNIT_MAX) begin
                            unit_ms   <= '0;
                            remaining <= remaining - ONE;
                            if (remaining == ONE) begin
                                time_out <= 1'b1;
                                busy     <= 1'b0;
                                state    <= DONE;
                            end
                        end else begin
                            unit_ms <= unit_ms + 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                DONE: begin
                    time_out <= 1'b0;
                    if (!start_delay)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_random_delay.sv
// Directed bench for random_delay with MS_DIV=4, DELAY_UNIT_MS=2,
// so each LFSR count is 8 clocks.
module tb_random_delay;
    import reaction_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_lfsr;
    logic       start_delay;
    logic       time_out;
    logic       busy;
    logic [6:0] delay_val;

    int checks = 0;
    int errors = 0;

    logic [6:0] m_lfsr;

    typedef struct {
        logic       en;
        logic [6:0] exp_lfsr;
        logic       exp_busy;
        logic       exp_to;
    } vec_t;

    vec_t vecs[5];

    random_delay #(
        .MS_DIV        (4),
        .DELAY_UNIT_MS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_lfsr     (en_lfsr),
        .start_delay (start_delay),
        .time_out    (time_out),
        .busy        (busy),
        .delay_val   (delay_val)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] m_step(input logic [6:0] v);
        if (v == 7'h00)
            return 7'h01;
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Step with en_lfsr until the model reaches target.
    task automatic seek_lfsr(input logic [6:0] target);
        int n = 0;
        en_lfsr = 1'b1;
        while (m_lfsr != target && n < 130) begin
            step_clk();
            m_lfsr = m_step(m_lfsr);
            n++;
        end
        en_lfsr = 1'b0;
        chk("seek_lfsr", 32'(dut.lfsr_q), 32'(target));
    endtask

    // Edges after the capture until time_out is seen, -1 if never.
    task automatic wait_pulse(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step_clk();
            if (time_out) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int pulses;

        vecs[0] = '{1'b1, 7'h02, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 7'h04, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 7'h08, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 7'h10, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 7'h20, 1'b0, 1'b0};

        rst_n       = 1'b0;
        en_lfsr     = 1'b0;
        start_delay = 1'b0;
        m_lfsr      = 7'h01;
        repeat (2) @(negedge clk);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'h01);
        chk("rst_to", 32'(time_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dval", 32'(delay_val), 32'd0);
        rst_n = 1'b1;
        step_clk();
        chk("idle_lfsr_hold", 32'(dut.lfsr_q), 32'h01);

        // 1: LFSR sequence
        foreach (vecs[i]) begin
            en_lfsr = vecs[i].en;
            step_clk();
            m_lfsr = m_step(m_lfsr);
            chk($sformatf("t1_lfsr%0d", i),
                32'(dut.lfsr_q), 32'(vecs[i].exp_lfsr));
            chk($sformatf("t1_busy%0d", i),
                32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("t1_to%0d", i),
                32'(time_out), 32'(vecs[i].exp_to));
        end
        en_lfsr = 1'b0;

        // 2: capture 05, expect pulse 40 clocks later
        seek_lfsr(7'h05);
        start_delay = 1'b1;
        step_clk();
        chk("t2_dval", 32'(delay_val), 32'h05);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_to0", 32'(time_out), 32'd0);
        wait_pulse(100, n);
        chk("t2_latency", 32'(n), 32'd40);

        // 3: linger with start held, no second pulse
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            if (time_out) pulses++;
        end
        chk("t3_pulses", 32'(pulses), 32'd0);
        chk("t3_busy_done", 32'(busy), 32'd0);
        start_delay = 1'b0;
        step_clk();
        chk("t3_idle", 32'(dut.state), 32'(IDLE));
        chk("t3_busy", 32'(busy), 32'd0);

        // 4: abort after 10 clocks
        start_delay = 1'b1;
        step_clk();
        chk("t4_busy_cap", 32'(busy), 32'd1);
        repeat (10) step_clk();
        chk("t4_busy_mid", 32'(busy), 32'd1);
        start_delay = 1'b0;
        step_clk();
        chk("t4_busy_abort", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step_clk();
            if (time_out) pulses++;
        end
        chk("t4_pulses", 32'(pulses), 32'd0);
        chk("t4_dval_kept", 32'(delay_val), 32'h05);

        // 5: minimum delay, en_lfsr high at capture
        seek_lfsr(7'h01);
        en_lfsr     = 1'b1;
        start_delay = 1'b1;
        step_clk();
        m_lfsr  = m_step(m_lfsr);
        en_lfsr = 1'b0;
        chk("t5_dval_prestep", 32'(delay_val), 32'h01);
        chk("t5_lfsr_stepped", 32'(dut.lfsr_q), 32'(m_lfsr));
        wait_pulse(30, n);
        chk("t5_latency", 32'(n), 32'd8);
        step_clk();
        chk("t5_one_cycle", 32'(time_out), 32'd0);
        start_delay = 1'b0;
        step_clk();

        // 6: async reset mid-run
        start_delay = 1'b1;
        step_clk();
        chk("t6_dval", 32'(delay_val), 32'h02);
        repeat (5) step_clk();
        chk("t6_busy_pre", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_to", 32'(time_out), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_dval0", 32'(delay_val), 32'd0);
        chk("t6_lfsr", 32'(dut.lfsr_q), 32'h01);
        @(negedge clk);
        rst_n       = 1'b1;
        start_delay = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            if (time_out) pulses++;
        end
        chk("t6_no_pulse", 32'(pulses), 32'd0);
        chk("t6_idle", 32'(dut.state), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
